// File: rtl/inst_ram_boot.sv
// rtl/inst_ram_boot.sv - loadable synchronous-read instruction RAM with byte-serial boot port
// Fetch is served with one cycle of latency in RUN; a boot load fills words little-endian and stalls fetch.
`timescale 1ns/1ps
module inst_ram_boot #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 16,
  parameter int DEPTH  = 256,
  parameter int CNT_W  = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ce,
  input  logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] inst,
  output logic              inst_valid,
  output logic              busy,
  input  logic              boot_start,
  input  logic [CNT_W-1:0]  boot_words,
  input  logic [7:0]        byte_in,
  input  logic              byte_valid,
  output logic              byte_ready,
  output logic              boot_done
);
  localparam int IDX_W = $clog2(DEPTH);

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    LOAD_LO = 2'd1,
    LOAD_HI = 2'd2
  } state_t;

  state_t            state;
  state_t            state_nx;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [IDX_W-1:0]  wr_ptr;
  logic [CNT_W-1:0]  count;
  logic [7:0]        lo_byte;
  logic              start_load;
  logic              start_empty;
  logic              take_lo;
  logic              take_hi;
  logic              last_word;
  logic [CNT_W-1:0]  words_clamped;
  logic [IDX_W-1:0]  rd_idx;
  logic              out_of_range;

  assign words_clamped = (boot_words > CNT_W'(DEPTH)) ? CNT_W'(DEPTH) : boot_words;
  assign last_word     = (CNT_W'(wr_ptr) == count - CNT_W'(1));
  assign rd_idx        = addr[IDX_W:1];
  // Any address bit above the word index selects outside the RAM.
  assign out_of_range  = ((addr >> (IDX_W + 1)) != '0);
  assign busy          = (state != RUN);
  assign byte_ready    = busy;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= RUN;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx    = state;
    start_load  = 1'b0;
    start_empty = 1'b0;
    take_lo     = 1'b0;
    take_hi     = 1'b0;
    case (state)
      RUN: begin
        if (boot_start) begin
          if (boot_words != '0) begin
            start_load = 1'b1;
            state_nx   = LOAD_LO;
          end else begin
            start_empty = 1'b1;
          end
        end
      end
      LOAD_LO: begin
        if (byte_valid) begin
          take_lo  = 1'b1;
          state_nx = LOAD_HI;
        end
      end
      LOAD_HI: begin
        if (byte_valid) begin
          take_hi  = 1'b1;
          state_nx = last_word ? RUN : LOAD_LO;
        end
      end
      default: state_nx = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr     <= '0;
      count      <= '0;
      lo_byte    <= '0;
      boot_done  <= 1'b0;
      inst       <= '0;
      inst_valid <= 1'b0;
    end else begin
      boot_done <= start_empty | (take_hi & last_word);
      if (start_load) begin
        wr_ptr <= '0;
        count  <= words_clamped;
      end else if (take_hi) begin
        wr_ptr <= wr_ptr + IDX_W'(1);
      end
      if (take_lo) begin
        lo_byte <= byte_in;
      end
      if (state == RUN && ce) begin
        inst_valid <= 1'b1;
        inst       <= out_of_range ? '0 : mem[rd_idx];
      end else begin
        inst_valid <= 1'b0;
        inst       <= '0;
      end
    end
  end

  // RAM contents survive reset so a partial load keeps its finished words.
  always_ff @(posedge clk) begin
    if (take_hi) begin
      mem[wr_ptr] <= DATA_W'({byte_in, lo_byte});
    end
  end
endmodule

// File: tb/tb_inst_ram_boot.sv
// tb/tb_inst_ram_boot.sv - self-checking bench for inst_ram_boot
`timescale 1ns/1ps
module tb_inst_ram_boot;
  localparam int DEPTH  = 256;
  localparam int ADDR_W = 16;
  localparam int DATA_W = 16;
  localparam int CNT_W  = 9;

  logic              clk = 1'b0;
  logic              rst;
  logic              ce;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] inst;
  logic              inst_valid;
  logic              busy;
  logic              boot_start;
  logic [CNT_W-1:0]  boot_words;
  logic [7:0]        byte_in;
  logic              byte_valid;
  logic              byte_ready;
  logic              boot_done;

  inst_ram_boot #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .ce(ce), .addr(addr), .inst(inst), .inst_valid(inst_valid),
    .busy(busy), .boot_start(boot_start), .boot_words(boot_words), .byte_in(byte_in),
    .byte_valid(byte_valid), .byte_ready(byte_ready), .boot_done(boot_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] a;
    logic        c;
    logic [15:0] ei;
    logic        ev;
  } vec_t;

  int          total = 0;
  int          bad = 0;
  logic [15:0] model [DEPTH];
  logic [7:0]  bq [$];
  logic [7:0]  spec_bytes [$];
  vec_t        tbl [$];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference fetch: word k lives at byte 2k; anything at or beyond 2*DEPTH reads as zero.
  function automatic logic [15:0] ref_fetch(input logic [15:0] a);
    if ((int'(a) / (2 * DEPTH)) != 0) return 16'h0000;
    return model[(int'(a) / 2) % DEPTH];
  endfunction

  task automatic fetch(input logic [15:0] a, input logic c, input logic [15:0] ei,
                       input logic ev, input string nm);
    ce   = c;
    addr = a;
    step();
    chk({nm, " inst"}, 32'(inst), 32'(ei));
    chk({nm, " valid"}, 32'(inst_valid), 32'(ev));
  endtask

  task automatic boot_load(input int nreq, input int gapmax, input bit poke);
    int n;
    int dones;
    int g;
    n = (nreq > DEPTH) ? DEPTH : nreq;
    ce         = 1'b0;
    boot_start = 1'b1;
    boot_words = CNT_W'(nreq);
    step();
    boot_start = 1'b0;
    if (n == 0) begin
      chk("empty done", 32'(boot_done), 1);
      chk("empty busy", 32'(busy), 0);
      step();
      chk("empty done clear", 32'(boot_done), 0);
      chk("empty busy after", 32'(busy), 0);
      return;
    end
    chk("start busy", 32'(busy), 1);
    chk("start ready", 32'(byte_ready), 1);
    chk("start done low", 32'(boot_done), 0);
    dones = 0;
    for (int i = 0; i < 2 * n; i++) begin
      g = (gapmax > 0) ? int'($urandom_range(gapmax, 0)) : 0;
      for (int j = 0; j < g; j++) begin
        byte_valid = 1'b0;
        byte_in    = 8'($urandom);
        if (poke) begin
          boot_start = 1'b1;
          boot_words = CNT_W'(1);
          ce         = 1'b1;
          addr       = 16'($urandom);
        end
        step();
        boot_start = 1'b0;
        chk("gap busy", 32'(busy), 1);
        chk("gap blocked inst", 32'(inst), 0);
        chk("gap blocked valid", 32'(inst_valid), 0);
      end
      byte_valid = 1'b1;
      byte_in    = bq[i];
      if (poke) begin
        ce   = 1'b1;
        addr = 16'($urandom);
      end
      step();
      byte_valid = 1'b0;
      ce         = 1'b0;
      chk("byte done", 32'(boot_done), 32'(i == 2 * n - 1));
      chk("byte busy", 32'(busy), 32'(i != 2 * n - 1));
      chk("load blocked valid", 32'(inst_valid), 0);
      if (boot_done) dones++;
    end
    for (int k = 0; k < n; k++) model[k] = {bq[2 * k + 1], bq[2 * k]};
    step();
    chk("done pulse count", 32'(dones + int'(boot_done)), 1);
    chk("busy after load", 32'(busy), 0);
  endtask

  task automatic run_table(input string nm);
    for (int i = 0; i < tbl.size(); i++) begin
      fetch(tbl[i].a, tbl[i].c, tbl[i].ei, tbl[i].ev, nm);
    end
    ce = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    spec_bytes = '{8'h69, 8'h01, 8'h10, 8'h02, 8'h41, 8'h21};
    tbl.push_back('{16'h0000, 1'b1, 16'h0169, 1'b1});
    tbl.push_back('{16'h0002, 1'b1, 16'h0210, 1'b1});
    tbl.push_back('{16'h0004, 1'b1, 16'h2141, 1'b1});
    tbl.push_back('{16'h0003, 1'b1, 16'h0210, 1'b1});
    tbl.push_back('{16'h0001, 1'b1, 16'h0169, 1'b1});
    tbl.push_back('{16'h0200, 1'b1, 16'h0000, 1'b1});
    tbl.push_back('{16'hFFFE, 1'b1, 16'h0000, 1'b1});
    tbl.push_back('{16'h0002, 1'b0, 16'h0000, 1'b0});
    tbl.push_back('{16'h0004, 1'b1, 16'h2141, 1'b1});

    // reset held with random inputs
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      ce         = 1'($urandom);
      addr       = 16'($urandom);
      boot_start = 1'($urandom);
      boot_words = CNT_W'($urandom);
      byte_in    = 8'($urandom);
      byte_valid = 1'($urandom);
      step();
    end
    chk("reset inst", 32'(inst), 0);
    chk("reset valid", 32'(inst_valid), 0);
    chk("reset busy", 32'(busy), 0);
    chk("reset ready", 32'(byte_ready), 0);
    chk("reset done", 32'(boot_done), 0);
    ce = 1'b0; boot_start = 1'b0; byte_valid = 1'b0; addr = '0; boot_words = '0;
    rst = 1'b1;
    step();
    chk("post reset busy", 32'(busy), 0);
    step();
    chk("post reset done", 32'(boot_done), 0);

    // gap-free load of the reference program, then the vector table
    bq = spec_bytes;
    boot_load(3, 0, 1'b0);
    run_table("tbl gapfree");

    // random words with gaps, plus ignored boot_start and blocked fetches mid-load
    bq.delete();
    for (int i = 0; i < 6; i++) bq.push_back(8'($urandom));
    boot_load(3, 3, 1'b1);
    for (int k = 0; k < 3; k++) fetch(16'(2 * k), 1'b1, ref_fetch(16'(2 * k)), 1'b1, "rand gapped");
    ce = 1'b0;

    // reference program again, gapped: same table must hold
    bq = spec_bytes;
    boot_load(3, 2, 1'b0);
    run_table("tbl gapped");

    // zero-word load leaves the RAM untouched
    boot_load(0, 0, 1'b0);
    fetch(16'h0000, 1'b1, 16'h0169, 1'b1, "after empty");
    ce = 1'b0;

    // oversize request is clamped to DEPTH words
    bq.delete();
    for (int i = 0; i < 2 * DEPTH; i++) bq.push_back(8'($urandom));
    boot_load(DEPTH + 5, 0, 1'b0);
    for (int i = 0; i < 300; i++) begin
      logic [15:0] a;
      logic        c;
      a = ($urandom_range(3, 0) == 0) ? 16'($urandom) : 16'($urandom_range(4 * DEPTH - 1, 0));
      c = ($urandom_range(3, 0) != 0);
      fetch(a, c, c ? ref_fetch(a) : 16'h0000, c, "rand fetch");
    end
    fetch(16'(2 * DEPTH - 2), 1'b1, model[DEPTH - 1], 1'b1, "last word");
    fetch(16'(2 * DEPTH), 1'b1, 16'h0000, 1'b1, "beyond depth");
    ce = 1'b0;

    // reset after 3 words plus a low byte
    bq.delete();
    for (int i = 0; i < 10; i++) bq.push_back(8'($urandom));
    boot_start = 1'b1;
    boot_words = CNT_W'(5);
    step();
    boot_start = 1'b0;
    for (int i = 0; i < 7; i++) begin
      byte_valid = 1'b1;
      byte_in    = bq[i];
      step();
    end
    byte_valid = 1'b0;
    for (int k = 0; k < 3; k++) model[k] = {bq[2 * k + 1], bq[2 * k]};
    rst = 1'b0;
    #1;
    chk("abort busy", 32'(busy), 0);
    chk("abort ready", 32'(byte_ready), 0);
    step();
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("abort no done", 32'(boot_done), 0);
      chk("abort idle", 32'(busy), 0);
    end
    for (int k = 0; k < 4; k++) fetch(16'(2 * k), 1'b1, ref_fetch(16'(2 * k)), 1'b1, "after abort");
    ce = 1'b0;

    // new load restarts at word 0
    bq = '{8'hAA, 8'hBB};
    boot_load(1, 0, 1'b0);
    fetch(16'h0000, 1'b1, 16'hBBAA, 1'b1, "reload w0");
    fetch(16'h0002, 1'b1, ref_fetch(16'h0002), 1'b1, "reload w1");
    ce = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/inst_ram_boot.md
# inst_ram_boot

Parametrised, loadable instruction memory for the THCO-MIPS fetch stage. It replaces the fixed combinational program table with a synchronous-read RAM that holds 16-bit instructions. A byte-serial boot port fills the RAM at run time, for example from the UART receiver. While the boot port is loading, the block stalls fetch; afterwards it serves instructions with one cycle of latency.

## Interface
Parameters:
- DATA_W, 16: instruction width in bits. Must be 16; one instruction is two boot bytes.
- ADDR_W, 16: width of the byte address on the fetch bus.
- DEPTH, 256: number of instruction words. Power of two, with log2(DEPTH)+1 <= ADDR_W.
- CNT_W, log2(DEPTH)+1: width of the word-count bus.

Ports:
- clk, in, 1: single clock. All state changes on the rising edge.
- rst, in, 1: asynchronous, active-low reset.
- ce, in, 1: fetch enable. Active high, matching `ChipEnable.
- addr, in, ADDR_W: byte address of the fetch. addr[0] is ignored.
- inst, out, DATA_W: registered instruction.
- inst_valid, out, 1: inst holds a valid fetch result this cycle.
- busy, out, 1: load in progress. The core must stall fetch while it is high.
- boot_start, in, 1: one-cycle pulse that starts a load.
- boot_words, in, CNT_W: number of words to load, sampled on boot_start.
- byte_in, in, 8: boot data byte.
- byte_valid, in, 1: byte_in is valid.
- byte_ready, out, 1: block accepts a byte this cycle.
- boot_done, out, 1: one-cycle pulse after the last word is written.

## Operation
- Storage is DEPTH x DATA_W. It is not cleared by reset; contents are undefined until loaded.
- State machine: RUN, LOAD_LO, LOAD_HI. Reset state is RUN.
- RUN:
  - On boot_start with boot_words != 0: set wr_ptr to 0, latch the word count, go to LOAD_LO.
  - On boot_start with boot_words == 0: stay in RUN and pulse boot_done the next cycle.
  - byte_valid is ignored.
- LOAD_LO: on byte_valid, latch byte_in as the low byte and go to LOAD_HI.
- LOAD_HI: on byte_valid, write {byte_in, low byte} to mem[wr_ptr] and increment wr_ptr.
  - If wr_ptr was count-1, go to RUN and assert boot_done.
  - Otherwise go to LOAD_LO.
- Byte order is little-endian: low byte first. Word k goes to byte address 2k.
- boot_words above DEPTH is clamped to DEPTH.
- boot_start during LOAD_LO or LOAD_HI is ignored.
- Fetch, in RUN only:
  - Word index is addr[log2(DEPTH):1].
  - If addr[ADDR_W-1:log2(DEPTH)+1] is nonzero (out of range), inst is 0 (`ZeroWord).
- Fetch with ce = 0: inst is 0 and inst_valid is 0.
- Fetch during LOAD_LO or LOAD_HI: inst is 0 and inst_valid is 0, whatever the value of ce.
- busy is 1 exactly when the state is LOAD_LO or LOAD_HI.
- byte_ready equals busy.

## Timing
- Reset values: inst = 0, inst_valid = 0, busy = 0, byte_ready = 0, boot_done = 0, state = RUN, wr_ptr = 0.
- Fetch latency is 1 cycle: addr and ce sampled at edge n produce inst and inst_valid after edge n.
  - Back-to-back fetches run at full rate, one per cycle.
- busy and byte_ready rise the cycle after boot_start.
- A byte is accepted on any edge where byte_valid and byte_ready are both high. There is no backpressure; the loader can take one byte per cycle.
- Memory write happens at the edge that accepts the high byte. A fetch of that word issued in the following cycle or later returns the new data.
- boot_done is high for the single cycle after the final write. busy falls in the same cycle, and fetch is live from that cycle on.
- Minimum load time is 2 x N cycles plus 1 cycle of start overhead.
- Reset asserted during a load:
  - Aborts the load immediately and returns to RUN.
  - Words already written are retained; the partial low byte is discarded.
  - No boot_done pulse is produced.

## Test plan
- Reset: hold rst = 0 with random inputs. Check that inst, inst_valid, busy, byte_ready and boot_done are all 0. Release reset; busy stays 0.
- Load and fetch: boot_start with boot_words = 3, then bytes 69 01 10 02 41 21.
  - boot_done pulses once after the 6th byte.
  - Fetches of addr 0000, 0002, 0004 return 0169, 0210, 2141, each one cycle later with inst_valid = 1.
- Gapped bytes: insert idle byte_valid cycles between bytes. Contents are identical to the gap-free case; busy holds through the gaps.
- Ignored and blocked requests, all during a load:
  - A second boot_start has no effect.
  - ce = 1 fetches give inst = 0 and inst_valid = 0.
- Boundary cases:
  - boot_words = 0: boot_done pulses and busy stays 0.
  - boot_words = DEPTH + 5: exactly DEPTH words are written, then done.
  - Fetch at byte address 2*DEPTH returns 0000.
  - addr 0003 returns the word at 0002.
- Reset mid-load: assert rst after 3 words plus a low byte.
  - After release, words 0 to 2 are intact and the state is RUN.
  - A new load starts again at word 0.
